// File: rtl/quiz_pkg.sv
// Shared constants and types for the quiz review screen: result codes, segment
// glyphs (active-low, bit7 = dp, bit6 = g ... bit0 = a), mode and scan-state enums.
package quiz_pkg;

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_OK      = 2'b01;
    localparam logic [1:0] RES_WRONG   = 2'b10;
    localparam logic [1:0] RES_TIMEOUT = 2'b11;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_Q     = 8'h98;
    localparam logic [7:0] SEG_P     = 8'h8C;
    localparam logic [7:0] GLYPH_A   = 8'h88;
    localparam logic [7:0] GLYPH_B   = 8'h83;
    localparam logic [7:0] GLYPH_0   = 8'hC0;

    typedef enum logic {
        MODE_QUESTION,
        MODE_SUMMARY
    } mode_t;

    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_RUN,
        SCAN_DONE
    } scan_state_t;

    function automatic logic [7:0] result_glyph(input logic [1:0] code);
        case (code)
            RES_OK:      return GLYPH_A;
            RES_WRONG:   return GLYPH_B;
            RES_TIMEOUT: return GLYPH_0;
            default:     return SEG_BLANK;
        endcase
    endfunction

    // Splits 0..15 into {tens, ones} BCD nibbles.
    function automatic logic [7:0] split_decimal(input logic [3:0] v);
        if (v >= 4'd10) begin
            return {4'd1, v - 4'd10};
        end
        return {4'd0, v};
    endfunction

endpackage

// File: rtl/bcd_seg.sv
// BCD digit to active-low seven-segment pattern; out-of-range values blank.
module bcd_seg (
    input  logic [3:0] value,
    output logic [7:0] seg
);

    always_comb begin
        case (value)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
    end

endmodule

// File: rtl/quiz_score_scan.sv
// Sequential tally of one player's list: one question per cycle, results latched
// one cycle after the last question; a start pulse restarts from question 1.
module quiz_score_scan
    import quiz_pkg::*;
#(
    parameter int MAX_Q = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         n,
    input  logic [MAX_Q*2-1:0] list,
    output logic [3:0]         correct,
    output logic [3:0]         wrong,
    output logic [MAX_Q-1:0]   mask,
    output logic               done
);

    scan_state_t      state_reg;
    logic [3:0]       idx_reg;
    logic [3:0]       ok_acc_reg;
    logic [3:0]       wrong_acc_reg;
    logic [MAX_Q-1:0] mask_acc_reg;
    logic [3:0]       correct_reg;
    logic [3:0]       wrong_reg;
    logic [MAX_Q-1:0] mask_reg;
    logic             done_reg;

    logic [MAX_Q-1:0] ok_hit;
    logic [MAX_Q-1:0] wrong_hit;

    // Decode the question under the cursor without a variable part-select.
    for (genvar gi = 0; gi < MAX_Q; gi++) begin : g_hit
        assign ok_hit[gi]    = (idx_reg == 4'(gi + 1)) && (list[gi*2 +: 2] == RES_OK);
        assign wrong_hit[gi] = (idx_reg == 4'(gi + 1)) && (list[gi*2 +: 2] == RES_WRONG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= SCAN_IDLE;
            idx_reg       <= '0;
            ok_acc_reg    <= '0;
            wrong_acc_reg <= '0;
            mask_acc_reg  <= '0;
            correct_reg   <= '0;
            wrong_reg     <= '0;
            mask_reg      <= '0;
            done_reg      <= 1'b0;
        end else if (start) begin
            state_reg     <= SCAN_RUN;
            idx_reg       <= 4'd1;
            ok_acc_reg    <= '0;
            wrong_acc_reg <= '0;
            mask_acc_reg  <= '0;
            correct_reg   <= '0;
            wrong_reg     <= '0;
            mask_reg      <= '0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                SCAN_RUN: begin
                    if (idx_reg <= n) begin
                        if (|ok_hit) ok_acc_reg <= ok_acc_reg + 4'd1;
                        if (|wrong_hit) wrong_acc_reg <= wrong_acc_reg + 4'd1;
                        mask_acc_reg <= mask_acc_reg | ok_hit;
                    end
                    if (idx_reg >= n) begin
                        state_reg <= SCAN_DONE;
                    end else begin
                        idx_reg <= idx_reg + 4'd1;
                    end
                end
                SCAN_DONE: begin
                    correct_reg <= ok_acc_reg;
                    wrong_reg   <= wrong_acc_reg;
                    mask_reg    <= mask_acc_reg;
                    done_reg    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign correct = correct_reg;
    assign wrong   = wrong_reg;
    assign mask    = mask_reg;
    assign done    = done_reg;

endmodule

// File: rtl/seg_tube.sv
// Eight-digit multiplexed tube driver: one digit lit at a time, advancing every
// SCAN_DIV cycles. seg_en is one-hot active-high, seg_out is active-low.
module seg_tube #(
    parameter int SCAN_DIV = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] digits,
    output logic [7:0]  seg_out,
    output logic [7:0]  seg_en
);

    localparam int DW = $clog2(SCAN_DIV + 1);

    logic [DW-1:0] div_reg;
    logic [2:0]    idx_reg;
    logic [7:0]    seg_out_reg;
    logic [7:0]    seg_en_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg     <= '0;
            idx_reg     <= '0;
            seg_out_reg <= 8'hFF;
            seg_en_reg  <= '0;
        end else begin
            if (div_reg == DW'(SCAN_DIV - 1)) begin
                div_reg <= '0;
                idx_reg <= idx_reg + 3'd1;
            end else begin
                div_reg <= div_reg + DW'(1);
            end
            seg_out_reg <= digits[{idx_reg, 3'b000} +: 8];
            seg_en_reg  <= 8'b1 << idx_reg;
        end
    end

    assign seg_out = seg_out_reg;
    assign seg_en  = seg_en_reg;

endmodule

// File: rtl/quiz_review_view.sv
// Answer-review screen: per-question results or per-player score summary on the
// tube, LEDs and a navigation beep. Optional macro AUTO_SCROLL_EN adds idle auto-advance.
module quiz_review_view
    import quiz_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int MAX_Q       = 9,
    parameter int VIEW_ID     = 4,
    parameter int BEEP_CYCLES = 5_000_000,
    parameter int AUTO_PERIOD = 200_000_000,
    parameter int SCAN_DIV    = 100_000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [2:0]                     view,
    input  logic [4:0]                     bt_edge,
    input  logic [3:0]                     play_count,
    input  logic [NUM_PLAYERS*MAX_Q*2-1:0] player_lists,
    output logic [7:0]                     seg_out,
    output logic [7:0]                     seg_en,
    output logic [23:0]                    led,
    output logic                           buzzer
);

    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int BW = $clog2(BEEP_CYCLES + 1);

    mode_t         mode_reg;
    logic [3:0]    q_reg;
    logic [PW-1:0] p_reg;
    logic [BW-1:0] beep_reg;
    logic [3:0]    pc_prev_reg;

    logic       active;
    logic [3:0] n_eff;
    logic       right, left, mode_btn;
    logic       mode_ok, nav_ok, accept;
    logic       step_fwd, step_back;
    logic       auto_fire;
    logic       scan_start;

    logic [MAX_Q*2-1:0]       list_sel;
    logic [NUM_PLAYERS*2-1:0] q_codes;
    logic [3:0]               scan_correct, scan_wrong;
    logic [MAX_Q-1:0]         scan_mask;
    logic                     scan_done;

    logic [27:0] bcd_vals;
    logic [55:0] bcd_segs;
    logic [7:0]  dig [8];
    logic [63:0] digit_bus;
    logic [23:0] led_next;

    assign active    = !rst && (view == 3'(VIEW_ID));
    assign n_eff     = (play_count > 4'(MAX_Q)) ? 4'(MAX_Q) : play_count;
    assign right     = bt_edge[0];
    assign left      = bt_edge[1];
    assign mode_btn  = bt_edge[2];
    assign mode_ok   = (n_eff != 4'd0) && mode_btn;
    assign nav_ok    = (n_eff != 4'd0) && !mode_btn && (right ^ left);
    assign accept    = mode_ok || nav_ok;
    assign step_fwd  = (nav_ok && right) || auto_fire;
    assign step_back = nav_ok && left;

    assign scan_start = active &&
        ((mode_ok && mode_reg == MODE_QUESTION) ||
         (mode_reg == MODE_SUMMARY && !mode_ok && (nav_ok || play_count != pc_prev_reg)));

`ifdef AUTO_SCROLL_EN
    localparam int AW = $clog2(AUTO_PERIOD + 1);
    logic [AW-1:0] idle_reg;

    assign auto_fire = active && mode_reg == MODE_QUESTION && n_eff != 4'd0 &&
                       bt_edge == 5'd0 && idle_reg == AW'(AUTO_PERIOD - 1);

    always_ff @(posedge clk) begin
        if (!active || mode_reg != MODE_QUESTION || n_eff == 4'd0 || bt_edge != 5'd0 || auto_fire) begin
            idle_reg <= '0;
        end else begin
            idle_reg <= idle_reg + AW'(1);
        end
    end
`else
    assign auto_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        pc_prev_reg <= play_count;
        if (!active) begin
            mode_reg <= MODE_QUESTION;
            q_reg    <= 4'd1;
            p_reg    <= '0;
            beep_reg <= '0;
        end else begin
            if (accept) begin
                beep_reg <= BW'(BEEP_CYCLES);
            end else if (beep_reg != '0) begin
                beep_reg <= beep_reg - BW'(1);
            end

            if (mode_ok) begin
                mode_reg <= (mode_reg == MODE_QUESTION) ? MODE_SUMMARY : MODE_QUESTION;
            end

            // A shrunken play_count pulls q back before any navigation applies.
            if (n_eff != 4'd0 && q_reg > n_eff) begin
                q_reg <= n_eff;
            end else if (mode_reg == MODE_QUESTION && !mode_ok) begin
                if (step_fwd) begin
                    q_reg <= (q_reg == n_eff) ? 4'd1 : q_reg + 4'd1;
                end else if (step_back) begin
                    q_reg <= (q_reg == 4'd1) ? n_eff : q_reg - 4'd1;
                end
            end

            if (mode_ok && mode_reg == MODE_QUESTION) begin
                p_reg <= '0;
            end else if (mode_reg == MODE_SUMMARY && nav_ok) begin
                if (right) begin
                    p_reg <= (p_reg == PW'(NUM_PLAYERS - 1)) ? '0 : p_reg + PW'(1);
                end else begin
                    p_reg <= (p_reg == '0) ? PW'(NUM_PLAYERS - 1) : p_reg - PW'(1);
                end
            end
        end
    end

    always_comb begin
        list_sel = '0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            if (p_reg == PW'(k)) list_sel = player_lists[k*MAX_Q*2 +: MAX_Q*2];
        end
    end

    always_comb begin
        q_codes = '0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            for (int j = 0; j < MAX_Q; j++) begin
                if (q_reg == 4'(j + 1)) q_codes[k*2 +: 2] = player_lists[(k*MAX_Q + j)*2 +: 2];
            end
        end
    end

    quiz_score_scan #(
        .MAX_Q(MAX_Q)
    ) u_scan (
        .clk     (clk),
        .rst     (!active),
        .start   (scan_start),
        .n       (n_eff),
        .list    (list_sel),
        .correct (scan_correct),
        .wrong   (scan_wrong),
        .mask    (scan_mask),
        .done    (scan_done)
    );

    // Nibbles: 0/1 q ones/tens, 2 player number, 3/4 correct ones/tens, 5/6 wrong ones/tens.
    assign bcd_vals = {split_decimal(scan_wrong), split_decimal(scan_correct),
                       4'(p_reg) + 4'd1, split_decimal(q_reg)};

    for (genvar gi = 0; gi < 7; gi++) begin : g_bcd
        bcd_seg u_bcd (
            .value (bcd_vals[gi*4 +: 4]),
            .seg   (bcd_segs[gi*8 +: 8])
        );
    end

    always_comb begin
        for (int k = 0; k < 8; k++) dig[k] = SEG_BLANK;
        if (active) begin
            if (n_eff == 4'd0) begin
                dig[0] = SEG_Q;
                dig[1] = SEG_DASH;
                dig[2] = SEG_DASH;
            end else if (mode_reg == MODE_QUESTION) begin
                dig[0] = SEG_Q;
                if (q_reg >= 4'd10) dig[1] = bcd_segs[15:8];
                dig[2] = bcd_segs[7:0];
                for (int k = 0; k < NUM_PLAYERS; k++) begin
                    dig[7-k] = result_glyph(q_codes[k*2 +: 2]);
                end
            end else begin
                dig[0] = SEG_P;
                dig[1] = bcd_segs[23:16];
                dig[4] = scan_done ? bcd_segs[39:32] : SEG_DASH;
                dig[5] = scan_done ? bcd_segs[31:24] : SEG_DASH;
                dig[6] = scan_done ? bcd_segs[55:48] : SEG_DASH;
                dig[7] = scan_done ? bcd_segs[47:40] : SEG_DASH;
            end
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_bus
        assign digit_bus[gi*8 +: 8] = dig[gi];
    end

    always_comb begin
        led_next = '0;
        if (active && n_eff != 4'd0) begin
            if (mode_reg == MODE_QUESTION) begin
                for (int k = 0; k < NUM_PLAYERS; k++) begin
                    led_next[k]      = q_codes[k*2 +: 2] == RES_OK;
                    led_next[8 + k]  = q_codes[k*2 +: 2] == RES_WRONG;
                    led_next[16 + k] = q_codes[k*2 +: 2] == RES_TIMEOUT;
                end
            end else begin
                for (int k = 0; k < MAX_Q; k++) led_next[k] = scan_mask[k] && scan_done;
            end
        end
    end

    assign led    = led_next;
    assign buzzer = active && (beep_reg != '0);

    seg_tube #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tube (
        .clk     (clk),
        .rst     (rst),
        .digits  (digit_bus),
        .seg_out (seg_out),
        .seg_en  (seg_en)
    );

endmodule

// File: tb/tb_quiz_review_view.sv
// Self-checking bench for quiz_review_view: directed steps plus randomized
// navigation, compared with a behavioural model of the review screen.
module tb_quiz_review_view;

    localparam int NP    = 4;
    localparam int MQ    = 9;
    localparam int VID   = 4;
    localparam int BEEP  = 20;
    localparam int AUTO  = 400;

    logic               clk = 1'b0;
    logic               rst;
    logic [2:0]         view;
    logic [4:0]         bt_edge;
    logic [3:0]         play_count;
    logic [NP*MQ*2-1:0] player_lists;
    logic [7:0]         seg_out;
    logic [7:0]         seg_en;
    logic [23:0]        led;
    logic               buzzer;

    int tests = 0;
    int fails = 0;

    int res [NP][MQ+1];
    int m_q, m_p, m_summary;

    logic [7:0]  obs_dig [8];
    logic [7:0]  exp_dig [8];
    logic [23:0] exp_led;
    logic [7:0]  num_seg [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    always #5 clk = ~clk;

    quiz_review_view #(
        .NUM_PLAYERS (NP),
        .MAX_Q       (MQ),
        .VIEW_ID     (VID),
        .BEEP_CYCLES (BEEP),
        .AUTO_PERIOD (AUTO),
        .SCAN_DIV    (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .view         (view),
        .bt_edge      (bt_edge),
        .play_count   (play_count),
        .player_lists (player_lists),
        .seg_out      (seg_out),
        .seg_en       (seg_en),
        .led          (led),
        .buzzer       (buzzer)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff_n();
        return (play_count > MQ) ? MQ : int'(play_count);
    endfunction

    function automatic logic [7:0] glyph(input int code);
        case (code)
            1:       return 8'h88;
            2:       return 8'h83;
            3:       return 8'hC0;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic pack_lists();
        player_lists = '0;
        for (int p = 0; p < NP; p++)
            for (int q = 1; q <= MQ; q++)
                player_lists[(p*MQ + q - 1)*2 +: 2] = res[p][q][1:0];
    endtask

    task automatic random_lists();
        for (int p = 0; p < NP; p++)
            for (int q = 1; q <= MQ; q++)
                res[p][q] = $urandom_range(0, 3);
        pack_lists();
    endtask

    // One clock after inputs change: the design pulls q back into range.
    task automatic settle();
        tick();
        if (eff_n() > 0 && m_q > eff_n()) m_q = eff_n();
    endtask

    task automatic press(input logic [4:0] b);
        int n;
        n = eff_n();
        if (n > 0) begin
            if (b[2]) begin
                m_summary = !m_summary;
                if (m_summary) m_p = 0;
            end else if (b[0] ^ b[1]) begin
                if (!m_summary) begin
                    if (b[0]) m_q = (m_q % n) + 1;
                    else      m_q = (m_q == 1) ? n : m_q - 1;
                end else begin
                    if (b[0]) m_p = (m_p + 1) % NP;
                    else      m_p = (m_p + NP - 1) % NP;
                end
            end
        end
        bt_edge = b;
        tick();
        bt_edge = '0;
    endtask

    task automatic build_expected();
        int n, c, w;
        n = eff_n();
        for (int k = 0; k < 8; k++) exp_dig[k] = 8'hFF;
        exp_led = '0;
        if (n == 0) begin
            exp_dig[0] = 8'h98;
            exp_dig[1] = 8'hBF;
            exp_dig[2] = 8'hBF;
        end else if (!m_summary) begin
            exp_dig[0] = 8'h98;
            exp_dig[2] = num_seg[m_q % 10];
            for (int k = 0; k < NP; k++) begin
                exp_dig[7-k] = glyph(res[k][m_q]);
                if (res[k][m_q] == 1) exp_led[k] = 1'b1;
                if (res[k][m_q] == 2) exp_led[8 + k] = 1'b1;
                if (res[k][m_q] == 3) exp_led[16 + k] = 1'b1;
            end
        end else begin
            c = 0;
            w = 0;
            for (int i = 1; i <= n; i++) begin
                if (res[m_p][i] == 1) begin
                    c++;
                    exp_led[i-1] = 1'b1;
                end
                if (res[m_p][i] == 2) w++;
            end
            exp_dig[0] = 8'h8C;
            exp_dig[1] = num_seg[m_p + 1];
            exp_dig[4] = num_seg[c / 10];
            exp_dig[5] = num_seg[c % 10];
            exp_dig[6] = num_seg[w / 10];
            exp_dig[7] = num_seg[w % 10];
        end
    endtask

    task automatic read_display();
        for (int k = 0; k < 8; k++) obs_dig[k] = 8'h00;
        repeat (8) begin
            tick();
            for (int k = 0; k < 8; k++)
                if (seg_en == (8'b1 << k)) obs_dig[k] = seg_out;
        end
    endtask

    task automatic check_view(input string tag);
        logic [63:0] o, e;
        build_expected();
        chk({tag, "_led"}, 64'(led), 64'(exp_led));
        read_display();
        for (int k = 0; k < 8; k++) begin
            o[k*8 +: 8] = obs_dig[k];
            e[k*8 +: 8] = exp_dig[k];
        end
        chk({tag, "_digits"}, o, e);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] b;
        rst = 1'b1;
        view = 3'(VID);
        bt_edge = '0;
        play_count = 4'd0;
        m_q = 1;
        m_p = 0;
        m_summary = 0;
        random_lists();
        repeat (3) tick();
        chk("rst_led", 64'(led), 64'd0);
        chk("rst_buzzer", 64'(buzzer), 64'd0);
        chk("rst_seg_en", 64'(seg_en), 64'd0);
        chk("rst_seg_out", 64'(seg_out), 64'hFF);

        // No questions played: "Q--" and buttons have no effect.
        rst = 1'b0;
        tick();
        check_view("n0");
        press(5'b00001);
        chk("n0_no_beep", 64'(buzzer), 64'd0);
        check_view("n0_right");
        press(5'b00100);
        chk("n0_mode_no_beep", 64'(buzzer), 64'd0);
        check_view("n0_mode");

        // Navigation wrap over three questions; q=2 carries a known pattern.
        play_count = 4'd3;
        res[0][2] = 1; res[1][2] = 0; res[2][2] = 2; res[3][2] = 3;
        pack_lists();
        settle();
        check_view("q1");
        press(5'b00001);
        chk("beep_on", 64'(buzzer), 64'd1);
        chk("q2_led_bits", 64'({led[19], led[10], led[0]}), 64'd7);
        check_view("q2");
        repeat (BEEP - 9) tick();
        chk("beep_hold", 64'(buzzer), 64'd1);
        tick();
        chk("beep_end", 64'(buzzer), 64'd0);
        press(5'b00001);
        check_view("q3");
        press(5'b00001);
        check_view("q_wrap_1");
        press(5'b00010);
        check_view("q_wrap_back_3");
        press(5'b00011);
        check_view("left_right_both");

        // Mode beats right in the same cycle: summary opens on player 1.
        press(5'b00101);
        repeat (5) tick();
        check_view("mode_priority");
        press(5'b00100);
        check_view("back_to_question");

        // Summary scan of player 1 over five questions.
        play_count = 4'd5;
        res[0][1] = 1; res[0][2] = 2; res[0][3] = 1; res[0][4] = 3; res[0][5] = 1;
        pack_lists();
        settle();
        press(5'b00100);
        for (int k = 0; k <= 5; k++) begin
            chk("scan_busy_led", 64'(led), 64'd0);
            if (k >= 1 && (seg_en == 8'h10 || seg_en == 8'h80))
                chk("scan_busy_dash", 64'(seg_out), 64'hBF);
            tick();
        end
        chk("scan_mask", 64'(led[4:0]), 64'b10101);
        check_view("summary_p1");

        // Restart mid-scan by moving to player 2 two cycles after entry.
        press(5'b00100);
        press(5'b00100);
        tick();
        press(5'b00001);
        for (int k = 0; k <= 5; k++) begin
            chk("restart_busy_led", 64'(led), 64'd0);
            tick();
        end
        check_view("restart_p2");

        // Randomized lists, play counts and buttons.
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 3) == 0) play_count = 4'($urandom_range(0, 15));
            if (!m_summary) random_lists();
            settle();
            case ($urandom_range(0, 4))
                0:       b = 5'b00001;
                1:       b = 5'b00010;
                2:       b = 5'b00100;
                3:       b = 5'b00011;
                default: b = 5'b00000;
            endcase
            press(b);
            repeat (11) tick();
            check_view($sformatf("rand%0d", it));
        end

        // Leaving the view mid-scan resets everything; re-entry starts at question 1.
        play_count = 4'd5;
        settle();
        if (!m_summary) press(5'b00100);
        else press(5'b00001);
        tick();
        view = 3'd3;
        tick();
        chk("away_led", 64'(led), 64'd0);
        chk("away_buzzer", 64'(buzzer), 64'd0);
        read_display();
        for (int k = 0; k < 8; k++) chk("away_digit", 64'(obs_dig[k]), 64'hFF);
        view = 3'(VID);
        m_q = 1;
        m_p = 0;
        m_summary = 0;
        tick();
        check_view("reentry");

`ifdef AUTO_SCROLL_EN
        press(5'b00001);
        repeat (AUTO + 5) tick();
        m_q = (m_q % eff_n()) + 1;
        chk("auto_no_beep", 64'(buzzer), 64'd0);
        check_view("auto_advance");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/quiz_review_view.md
Name: quiz_review_view

Overview:
Parametrised answer-review screen for the quiz buzzer game, active when top-level `view` equals VIEW_ID. It has two modes:
- QUESTION mode: step through played questions; all players' results for the selected question show at once.
- SUMMARY mode: step through players; a sequential scan engine tallies each player's correct and wrong counts.

The block drives the 8-digit tube through an internal seg_tube instance, plus 24 LEDs and the buzzer.

Parameters:
NUM_PLAYERS, 4, number of players (1..4).
MAX_Q, 9, question slots per player list (1..15).
VIEW_ID, 4, value of `view` that activates this block.
BEEP_CYCLES, 5_000_000, buzzer pulse length on each accepted navigation.
AUTO_PERIOD, 200_000_000, idle cycles before auto-advance (used only with AUTO_SCROLL_EN).

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
view  in  3  current top-level view id
bt_edge  in  5  one-cycle button pulses: [0]=right, [1]=left, [2]=mode toggle
play_count  in  4  number of questions played
player_lists  in  NUM_PLAYERS*MAX_Q*2  player p, question q (1-based) result at bits [(p*MAX_Q+q-1)*2 +: 2]
seg_out  out  8  segment drive from seg_tube (active-low)
seg_en  out  8  digit enable from seg_tube
led  out  24  result LEDs
buzzer  out  1  navigation beep

Behaviour:
- Result code: 00 = none, 01 = correct (glyph 'A'), 10 = wrong (glyph 'b'), 11 = timeout (glyph '0').
- Effective count: n = min(play_count, MAX_Q).
- Inactive/reset:
  - Condition: rst=1 or view≠VIEW_ID.
  - Effect: mode=QUESTION, q=1, player cursor p=0, scan idle, led=0, buzzer=0, all digits SEG_BLANK.
  - Entering VIEW_ID always starts in QUESTION mode with q=1.
- n=0:
  - Digits show "Q--" with the rest blank.
  - All buttons are ignored, led=0.
- Navigation:
  - right and left in the same cycle: no action.
  - QUESTION mode: right gives q = (q==n) ? 1 : q+1; left gives q = (q==1) ? n : q-1.
  - SUMMARY mode: p wraps over 0..NUM_PLAYERS-1 the same way.
  - A mode pulse toggles the mode. Entering SUMMARY sets p=0 and starts a scan.
  - mode takes priority over left/right in the same cycle.
  - If play_count shrinks below q, q clamps to n on the next cycle.
- QUESTION display:
  - d0=SEG_Q, d1=blank, d2=BCD(q), d3=blank.
  - d(7-k) = glyph of player k, or blank if the code is 00.
  - led[k] = correct, led[8+k] = wrong, led[16+k] = timeout. Updates the cycle after q changes.
- Scan engine (states IDLE, SCAN, DONE):
  - Starts on entry to SUMMARY, on any p change, or on any play_count change while in SUMMARY.
  - One question examined per cycle, i = 1..n, accumulating correct and wrong counts (4 bits each).
  - Results are latched to display registers in DONE, n+1 cycles after start. A restart mid-scan clears the accumulators and begins again from i=1.
  - While not DONE, digits 4..7 show SEG_DASH.
- SUMMARY display:
  - d0=SEG_P, d1=BCD(p+1), d2, d3 blank.
  - d4,d5 = correct count as two decimal digits; d6,d7 = wrong count.
  - led[i-1] = 1 for each question i that player p answered correctly (latched at DONE).
- Buzzer:
  - Each accepted left/right/mode pulse loads a counter with BEEP_CYCLES; buzzer=1 while the counter is nonzero.
  - A new pulse reloads the counter.

Optional Feature:
AUTO_SCROLL_EN:
- Defined: in QUESTION mode with n>0, an idle counter advances q as if right were pressed after AUTO_PERIOD cycles with no bt_edge pulse. The auto-advance does not beep. Any button or a mode change clears the counter.
- Undefined: no idle counter is built; q changes only on buttons.

Decomposition:
- Package quiz_pkg:
  - Result codes: RES_NONE, RES_OK, RES_WRONG, RES_TIMEOUT.
  - Segment constants: SEG_BLANK=8'hFF, SEG_DASH=8'hBF, SEG_Q, SEG_P.
  - Glyph codes A/b/0.
  - Mode enum (MODE_QUESTION, MODE_SUMMARY) and scan-state enum.
- One sub-module, quiz_score_scan: the scan engine (start, player index, list slice in; counts, correct mask, done out).
- Reuses existing seg_tube and bcd_seg.

Test Plan:
- Navigation wrap: play_count=3, view=4; press right ×3, then left ×1. Required: q goes 1→2→3→1→3, buzzer high BEEP_CYCLES after each press.
- Question results: at q=2, players 1..4 coded 01,00,10,11. Required: d7='A', d6 blank, d5='b', d4='0'; led[0]=1, led[10]=1, led[19]=1.
- Summary scan: play_count=5, player1 list = 01,10,01,11,01; mode pulse. Required: dashes for 6 cycles, then d4..d7 = "0 3 0 1" and led[4:0]=10101b.
- Restart mid-scan: press right 2 cycles after entering SUMMARY. Required: p=1, the scan restarts, and counts reflect player 2 only.
- Boundaries: play_count=0 → "Q--" and buttons ignored; left+right together → no change; view switches away mid-scan → all outputs reset, and re-entry gives QUESTION mode with q=1.
- AUTO_SCROLL_EN (reduced AUTO_PERIOD=10): no buttons for 10 cycles → q advances by 1 with no beep.
